dram_sim_req_arbiter: RTL and testbench

// Shares the single request/response channel of the DRAMsys co-simulation bridge among NumPorts requesters.

---
 rtl/dram_sim_req_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_dram_sim_req_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_sim_req_arbiter.sv
// Request/response arbiter in front of the DRAMsys co-simulation bridge.
// Round-robin grant with burst locking; an in-order ID FIFO remembers which
// port issued each outstanding transaction so responses can be routed back.
//
// Handshake rule (request and response channels alike): a beat transfers in
// any cycle where valid and ready are both high at the rising clock edge.
// valid must not depend on ready, and once raised it stays high with stable
// payload until the beat transfers.
module dram_sim_req_arbiter #(
  parameter int NumPorts       = 4,
  parameter int AddrWidth      = 32,
  parameter int DataWidth      = 64,
  parameter int MaxOutstanding = 8,
  localparam int IdWidth       = $clog2(NumPorts),
  localparam int PtrWidth      = $clog2(MaxOutstanding),
  localparam int CntWidth      = $clog2(MaxOutstanding) + 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  // requester side
  input  logic [NumPorts-1:0]           req_valid_i,
  output logic [NumPorts-1:0]           req_ready_o,
  input  logic [NumPorts*AddrWidth-1:0] req_addr_i,
  input  logic [NumPorts-1:0]           req_write_i,
  input  logic [NumPorts*DataWidth-1:0] req_data_i,
  input  logic [NumPorts-1:0]           req_last_i,
  // bridge request side
  output logic                          dram_req_valid_o,
  input  logic                          dram_req_ready_i,
  output logic [AddrWidth-1:0]          dram_req_addr_o,
  output logic                          dram_req_write_o,
  output logic [DataWidth-1:0]          dram_req_data_o,
  output logic                          dram_req_last_o,
  output logic [IdWidth-1:0]            dram_req_id_o,
  // bridge response side
  input  logic                          dram_rsp_valid_i,
  output logic                          dram_rsp_ready_o,
  input  logic [DataWidth-1:0]          dram_rsp_data_i,
  input  logic                          dram_rsp_last_i,
  // requester response side
  output logic [NumPorts-1:0]           rsp_valid_o,
  input  logic [NumPorts-1:0]           rsp_ready_i,
  output logic [DataWidth-1:0]          rsp_data_o,
  output logic                          rsp_last_o,
  // debug visibility of internal state
  output logic                          dbg_state_o,
  output logic [CntWidth-1:0]           dbg_count_o,
  output logic [IdWidth-1:0]            dbg_rr_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [IdWidth-1:0]  grant_q, grant_d;
  logic [IdWidth-1:0]  rr_q, rr_d;
  logic [IdWidth-1:0]  pick, sel;
  logic                found, active, req_hs, push, pop;

  logic [IdWidth-1:0]  fifo_mem [MaxOutstanding];
  logic [PtrWidth-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntWidth-1:0] count_q;
  logic                full, empty;
  logic [IdWidth-1:0]  head;

  assign full  = (count_q == CntWidth'(MaxOutstanding));
  assign empty = (count_q == '0);
  assign head  = fifo_mem[rd_ptr_q];

  // Response routing: the FIFO head owns the current response stream.
  always_comb begin
    rsp_valid_o      = '0;
    dram_rsp_ready_o = 1'b0;
    rsp_data_o       = '0;
    rsp_last_o       = 1'b0;
    if (!empty) begin
      rsp_valid_o[head] = dram_rsp_valid_i;
      dram_rsp_ready_o  = rsp_ready_i[head];
      rsp_data_o        = dram_rsp_data_i;
      rsp_last_o        = dram_rsp_last_i;
    end
  end

  assign pop = dram_rsp_valid_i && dram_rsp_ready_o && dram_rsp_last_i;

  // Round-robin search: first valid requester at or after the rr pointer.
  always_comb begin
    int unsigned idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 0; i < NumPorts; i++) begin
      idx = (int'(rr_q) + i) % NumPorts;
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        pick  = IdWidth'(idx);
      end
    end
  end

  // FSM next state: grant in IDLE (a pop in the same cycle frees the slot
  // a full FIFO would otherwise block), hold the grant until the last beat.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    active  = 1'b0;
    sel     = '0;
    case (state_q)
      IDLE: begin
        if (rst_ni && found && (!full || pop)) begin
          active  = 1'b1;
          sel     = pick;
          grant_d = pick;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        active = rst_ni;
        sel    = grant_q;
      end
      default: state_d = IDLE;
    endcase
    req_hs = active && req_valid_i[sel] && dram_req_ready_i;
    push   = req_hs && req_last_i[sel];
    if (push) begin
      state_d = IDLE;
      rr_d    = IdWidth'((int'(sel) + 1) % NumPorts);
    end
  end

  // Request mux: only the granted port sees the bridge.
  always_comb begin
    req_ready_o      = '0;
    dram_req_valid_o = 1'b0;
    dram_req_addr_o  = '0;
    dram_req_write_o = 1'b0;
    dram_req_data_o  = '0;
    dram_req_last_o  = 1'b0;
    dram_req_id_o    = '0;
    if (active) begin
      req_ready_o[sel] = dram_req_ready_i;
      dram_req_valid_o = req_valid_i[sel];
      dram_req_addr_o  = req_addr_i[sel*AddrWidth +: AddrWidth];
      dram_req_write_o = req_write_i[sel];
      dram_req_data_o  = req_data_i[sel*DataWidth +: DataWidth];
      dram_req_last_o  = req_last_i[sel];
      dram_req_id_o    = sel;
    end
  end

  // FSM, grant and round-robin pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
    end
  end

  // ID FIFO pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // ID FIFO storage; contents are only meaningful below the count.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= sel;
  end

  assign dbg_state_o = state_q;
  assign dbg_count_o = count_q;
  assign dbg_rr_o    = rr_q;

  // Protocol checks on both channels.
  for (genvar p = 0; p < NumPorts; p++) begin : g_req_chk
    a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (req_valid_i[p] && !req_ready_o[p]) |=>
        (req_valid_i[p] && $stable(req_addr_i[p*AddrWidth +: AddrWidth]) &&
         $stable(req_write_i[p])));
    a_read_last: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (req_valid_i[p] && !req_write_i[p]) |-> req_last_i[p]);
  end

  a_rsp_not_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    dram_rsp_valid_i |-> !empty);

endmodule

// File: tb/tb_dram_sim_req_arbiter.sv
// Directed bench for dram_sim_req_arbiter (4 ports, 8 outstanding).
module tb_dram_sim_req_arbiter;

  localparam int NP = 4;
  localparam int AW = 32;
  localparam int DW = 64;
  localparam int MO = 8;

  // clock/reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NP-1:0]    req_valid, req_ready, req_write, req_last;
  logic [NP*AW-1:0] req_addr;
  logic [NP*DW-1:0] req_data;
  logic             dram_req_valid, dram_req_ready, dram_req_write, dram_req_last;
  logic [AW-1:0]    dram_req_addr;
  logic [DW-1:0]    dram_req_data;
  logic [1:0]       dram_req_id;
  logic             dram_rsp_valid, dram_rsp_ready, dram_rsp_last;
  logic [DW-1:0]    dram_rsp_data;
  logic [NP-1:0]    rsp_valid, rsp_ready;
  logic [DW-1:0]    rsp_data;
  logic             rsp_last;
  logic             dbg_state;
  logic [3:0]       dbg_count;
  logic [1:0]       dbg_rr;

  dram_sim_req_arbiter #(
    .NumPorts(NP), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_write_i(req_write), .req_data_i(req_data), .req_last_i(req_last),
    .dram_req_valid_o(dram_req_valid), .dram_req_ready_i(dram_req_ready),
    .dram_req_addr_o(dram_req_addr), .dram_req_write_o(dram_req_write),
    .dram_req_data_o(dram_req_data), .dram_req_last_o(dram_req_last),
    .dram_req_id_o(dram_req_id),
    .dram_rsp_valid_i(dram_rsp_valid), .dram_rsp_ready_o(dram_rsp_ready),
    .dram_rsp_data_i(dram_rsp_data), .dram_rsp_last_i(dram_rsp_last),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data), .rsp_last_o(rsp_last),
    .dbg_state_o(dbg_state), .dbg_count_o(dbg_count), .dbg_rr_o(dbg_rr)
  );

  // scoreboard: port ids of outstanding transactions, oldest first
  logic [1:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change at the falling edge, checks 1ns later
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int p, input logic v, input logic w, input logic l,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[p]         = v;
    req_write[p]         = w;
    req_last[p]          = l;
    req_addr[p*AW +: AW] = a;
    req_data[p*DW +: DW] = d;
  endtask

  task automatic clear_inputs();
    req_valid      = '0;
    req_write      = '0;
    req_last       = '1;
    req_addr       = '0;
    req_data       = '0;
    dram_req_ready = 1'b0;
    dram_rsp_valid = 1'b0;
    dram_rsp_last  = 1'b0;
    dram_rsp_data  = '0;
    rsp_ready      = '0;
  endtask

  initial begin
    logic [1:0] exp_id;
    logic       had_rsp;
    clear_inputs();

    // ---- reset state
    @(negedge clk);
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    chk("rst_dram_valid", 64'(dram_req_valid), 64'h0);
    chk("rst_dram_addr", 64'(dram_req_addr), 64'h0);
    chk("rst_dram_id", 64'(dram_req_id), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_rsp_ready", 64'(dram_rsp_ready), 64'h0);
    chk("rst_count", 64'(dbg_count), 64'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // ---- single port 0 read, zero-latency grant
    dram_req_ready = 1'b1;
    rsp_ready      = '1;
    set_req(0, 1'b1, 1'b0, 1'b1, 32'h100, '0);
    #1;
    chk("p0_ready", 64'(req_ready), 64'h1);
    chk("p0_dvalid", 64'(dram_req_valid), 64'h1);
    chk("p0_id", 64'(dram_req_id), 64'h0);
    chk("p0_addr", 64'(dram_req_addr), 64'h100);
    tick();
    req_valid[0] = 1'b0;
    #1;
    chk("p0_count", 64'(dbg_count), 64'h1);
    chk("p0_rr", 64'(dbg_rr), 64'h1);
    dram_rsp_valid = 1'b1;
    dram_rsp_last  = 1'b1;
    dram_rsp_data  = 64'hDEAD_BEEF_0000_0001;
    #1;
    chk("p0_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("p0_rsp_data", rsp_data, 64'hDEAD_BEEF_0000_0001);
    chk("p0_rsp_ready", 64'(dram_rsp_ready), 64'h1);
    tick();
    dram_rsp_valid = 1'b0;
    #1;
    chk("p0_empty", 64'(dbg_count), 64'h0);

    // ---- all four ports reading continuously; rr starts at 1
    for (int p = 0; p < NP; p++) set_req(p, 1'b1, 1'b0, 1'b1, 32'(32'h1000 + p * 16), '0);
    for (int i = 0; i < 16; i++) begin
      exp_id = 2'((1 + i) % NP);
      had_rsp = (exp_q.size() > 0);
      dram_rsp_valid = had_rsp;
      #1;
      chk("rr_id", 64'(dram_req_id), 64'(exp_id));
      chk("rr_ready", 64'(req_ready), 64'(4'b0001 << exp_id));
      if (had_rsp) chk("rr_rsp_route", 64'(rsp_valid), 64'(4'b0001 << exp_q[0]));
      tick();
      if (had_rsp) void'(exp_q.pop_front());
      exp_q.push_back(exp_id);
      if (i >= 12) req_valid[exp_id] = 1'b0;
    end
    dram_rsp_valid = 1'b1;
    #1;
    chk("rr_drain_route", 64'(rsp_valid), 64'(4'b0001 << exp_q[0]));
    tick();
    void'(exp_q.pop_front());
    dram_rsp_valid = 1'b0;
    #1;
    chk("rr_empty", 64'(dbg_count), 64'h0);

    // ---- port 1 4-beat write burst while port 2 waits
    set_req(2, 1'b1, 1'b0, 1'b1, 32'h2000, '0);
    for (int b = 0; b < 4; b++) begin
      set_req(1, 1'b1, 1'b1, (b == 3), 32'h3000, 64'(64'hA0 + b));
      #1;
      chk("burst_id", 64'(dram_req_id), 64'h1);
      chk("burst_ready", 64'(req_ready), 64'h2);
      chk("burst_data", dram_req_data, 64'(64'hA0 + b));
      tick();
      if (b == 0) chk("burst_locked", 64'(dbg_state), 64'h1);
    end
    exp_q.push_back(2'd1);
    req_valid[1] = 1'b0;
    #1;
    chk("after_burst_id", 64'(dram_req_id), 64'h2);
    chk("after_burst_ready", 64'(req_ready), 64'h4);
    tick();
    exp_q.push_back(2'd2);
    req_valid[2] = 1'b0;
    for (int r = 0; r < 2; r++) begin
      dram_rsp_valid = 1'b1;
      #1;
      chk("burst_rsp_route", 64'(rsp_valid), 64'(4'b0001 << exp_q[0]));
      tick();
      void'(exp_q.pop_front());
    end
    dram_rsp_valid = 1'b0;

    // ---- fill the FIFO with responses held off
    set_req(0, 1'b1, 1'b0, 1'b1, 32'h4000, '0);
    for (int i = 0; i < MO; i++) begin
      #1;
      chk("fill_ready", 64'(req_ready), 64'h1);
      tick();
    end
    #1;
    chk("full_count", 64'(dbg_count), 64'h8);
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("full_no_ready", 64'(req_ready), 64'h0);
      chk("full_no_dvalid", 64'(dram_req_valid), 64'h0);
      tick();
    end

    // ---- full FIFO: same-cycle pop and new single-beat request
    dram_rsp_valid = 1'b1;
    #1;
    chk("full_pop_route", 64'(rsp_valid), 64'h1);
    chk("full_pop_req_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid[0] = 1'b0;
    dram_rsp_valid = 1'b0;
    #1;
    chk("full_pushpop_count", 64'(dbg_count), 64'h8);
    dram_rsp_valid = 1'b1;
    repeat (5) tick();
    dram_rsp_valid = 1'b0;
    #1;
    chk("drain_count", 64'(dbg_count), 64'h3);

    // ---- reset mid write burst with 3 outstanding
    set_req(3, 1'b1, 1'b1, 1'b0, 32'h5000, 64'hB0);
    #1;
    chk("mid_id", 64'(dram_req_id), 64'h3);
    tick();
    set_req(3, 1'b1, 1'b1, 1'b0, 32'h5000, 64'hB1);
    rst_n = 1'b0;
    #1;
    chk("mrst_req_ready", 64'(req_ready), 64'h0);
    chk("mrst_dvalid", 64'(dram_req_valid), 64'h0);
    chk("mrst_count", 64'(dbg_count), 64'h0);
    chk("mrst_rr", 64'(dbg_rr), 64'h0);
    chk("mrst_state", 64'(dbg_state), 64'h0);
    chk("mrst_rsp_ready", 64'(dram_rsp_ready), 64'h0);
    clear_inputs();
    tick();
    rst_n = 1'b1;
    dram_req_ready = 1'b1;
    rsp_ready      = '1;
    tick();
    set_req(2, 1'b1, 1'b0, 1'b1, 32'h6000, '0);
    #1;
    chk("post_rst_id", 64'(dram_req_id), 64'h2);
    chk("post_rst_ready", 64'(req_ready), 64'h4);
    tick();
    req_valid[2] = 1'b0;
    dram_rsp_valid = 1'b1;
    dram_rsp_last  = 1'b1;
    #1;
    chk("post_rst_count", 64'(dbg_count), 64'h1);
    chk("post_rst_route", 64'(rsp_valid), 64'h4);
    tick();
    dram_rsp_valid = 1'b0;
    #1;
    chk("post_rst_empty", 64'(dbg_count), 64'h0);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
